// File: rtl/pipeline_ctrl.sv
// Valid/ready sequencer for a DEPTH-stage datapath: bubble-collapsing stage enables,
// flush and drain control, plus occupancy and output-stall statistics.
module pipeline_ctrl #(
   parameter int DEPTH   = 8,
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               flush,
   input  logic               drain_req,
   output logic               drain_done,
   output logic [DEPTH-1:0]   stage_en,
   output logic [DEPTH-1:0]   stage_vld,
   output logic [4:0]         occupancy,
   output logic [1:0]         state,
   output logic [STALL_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [DEPTH-1:0]   vld_q, vld_d;
   logic [4:0]         occupancy_q, occupancy_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic               drain_done_q, drain_done_d;
   logic [DEPTH-1:0]   rdy;
   logic               accept;

   // A stage can load if it is empty or its occupant moves on; readiness ripples from the output back.
   always_comb begin
      logic r;
      rdy = '0;
      r   = ~vld_q[DEPTH-1] | out_ready;
      rdy[DEPTH-1] = r;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         r      = ~vld_q[i] | r;
         rdy[i] = r;
      end
   end

   assign stage_en = rdy & {DEPTH{~flush}};

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      in_ready = 1'b0;
      if ((state_q == IDLE || state_q == RUN) && !flush && !drain_req) begin
         in_ready = rdy[0];
      end
   end

   assign accept = in_valid & in_ready;

   always_comb begin
      vld_d = vld_q;
      if (flush) begin
         vld_d = '0;
      end else begin
         if (stage_en[0]) vld_d[0] = accept;
         for (int i = 1; i < DEPTH; i++) begin
            if (stage_en[i]) vld_d[i] = vld_q[i-1];
         end
      end
   end

   // Occupancy is registered from the next valid vector so it always matches stage_vld.
   always_comb begin
      occupancy_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy_d = occupancy_d + 5'(vld_d[i]);
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (vld_q[DEPTH-1] && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (drain_req)   state_d = DRAIN;
            else if (accept) state_d = RUN;
         end
         RUN: begin
            if (drain_req)               state_d = DRAIN;
            else if (occupancy_d == '0)  state_d = IDLE;
         end
         DRAIN: begin
            if (occupancy_d == '0) state_d = IDLE;
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = FLUSH;
      drain_done_d = (state_q == DRAIN) && (state_d == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         vld_q        <= '0;
         occupancy_q  <= '0;
         stall_cnt_q  <= '0;
         drain_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vld_q        <= vld_d;
         occupancy_q  <= occupancy_d;
         stall_cnt_q  <= stall_cnt_d;
         drain_done_q <= drain_done_d;
      end
   end

   assign out_valid  = vld_q[DEPTH-1];
   assign stage_vld  = vld_q;
   assign occupancy  = occupancy_q;
   assign state      = state_q;
   assign stall_cnt  = stall_cnt_q;
   assign drain_done = drain_done_q;

endmodule
